// File: rtl/mem_request_ctrl_pkg.sv
// Shared definitions for the main-memory request controller: FSM encoding and
// refill block geometry.
package mem_request_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam int BLOCK_WORDS = 4;
  localparam int BLK_OFF_W   = 2;

endpackage

// File: rtl/mem_request_ctrl_if.sv
// Main-memory request bus: the controller is the master, the memory the slave.
interface mem_request_ctrl_if
  import mem_request_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]            mem_address;
  logic                         mem_write_en;
  logic                         mem_read_en;
  logic [WIDTH-1:0]             mem_write_data;
  logic                         mem_ready;
  logic [BLOCK_WORDS*WIDTH-1:0] mem_read_data;
  logic                         mem_error;

  modport master (
    output mem_address, mem_write_en, mem_read_en, mem_write_data, mem_error,
    input  mem_ready, mem_read_data
  );

  modport slave (
    input  mem_address, mem_write_en, mem_read_en, mem_write_data, mem_error,
    output mem_ready, mem_read_data
  );

endinterface

// File: rtl/mem_wbuf_fifo.sv
// Circular write buffer holding pending write-through stores (address + data).
// Push is refused while full, even if a pop happens in the same cycle.
module mem_wbuf_fifo #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [WIDTH-1:0]  head_data
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  logic [ADDR_W-1:0] addr_mem [WBUF_DEPTH];
  logic [WIDTH-1:0]  data_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(WBUF_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/mem_request_ctrl.sv
// Main-memory initiator: drains buffered write-through stores and issues
// 4-word refill reads, one request at a time. Optional MEM_REQ_TIMEOUT_EN
// adds a ready-wait timeout with a sticky mem_error flag.
module mem_request_ctrl
  import mem_request_ctrl_pkg::*;
#(
  parameter int  WIDTH       = 32,
  parameter int  DEPTH       = 1024,
  parameter int  WBUF_DEPTH  = 4,
  parameter int  TIMEOUT_CYC = 255,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         wr_accept,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_done,
  output logic [BLOCK_WORDS*WIDTH-1:0] rd_block,
  output logic                         wbuf_empty,
  output logic                         busy,
  mem_request_ctrl_if.master           mem
);

  localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-BLK_OFF_W){1'b1}}, {BLK_OFF_W{1'b0}}};

  state_t            state, state_nxt;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W-1:0] head_addr, addr_q;
  logic [WIDTH-1:0]  head_data, wdata_q;
  logic              waiting, tmo, finish;

  assign wr_accept  = wr_req && !fifo_full;
  assign wbuf_empty = fifo_empty;
  assign waiting    = (state == ST_WRITE) || (state == ST_READ);
  assign finish     = mem.mem_ready || tmo;
  assign fifo_pop   = (state == ST_WRITE) && finish;

  mem_wbuf_fifo #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .WBUF_DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk(clk), .reset(reset),
    .push(wr_req), .push_addr(wr_addr), .push_data(wr_data),
    .pop(fifo_pop), .full(fifo_full), .empty(fifo_empty),
    .head_addr(head_addr), .head_data(head_data)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign tmo = waiting && !mem.mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (!waiting)            wait_cnt <= '0;
      else if (!mem.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
      if (tmo) err_q <= 1'b1;
    end
  end

  assign mem.mem_error = err_q;
`else
  assign tmo = 1'b0;
  // Constant 0 in this build; the timeout limit has no effect here.
  assign mem.mem_error = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Pending stores win over a refill so memory is current before any read.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty)  state_nxt = ST_WRITE;
        else if (rd_req)  state_nxt = ST_READ;
      end
      ST_WRITE, ST_READ: if (finish) state_nxt = ST_RECOVER;
      ST_RECOVER:        state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_write_en   = (state == ST_WRITE);
    mem.mem_read_en    = (state == ST_READ);
    mem.mem_address    = addr_q;
    mem.mem_write_data = wdata_q;
    busy               = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_block <= '0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= (state == ST_READ) && finish;
      if (state == ST_IDLE) begin
        if (!fifo_empty) begin
          addr_q  <= head_addr;
          wdata_q <= head_data;
        end else if (rd_req) begin
          addr_q <= rd_addr & BLK_MASK;
        end
      end
      // An abandoned refill hands back an all-zero block.
      if (state == ST_READ) begin
        if (mem.mem_ready) rd_block <= mem.mem_read_data;
        else if (tmo)      rd_block <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Self-checking bench for mem_request_ctrl: table-driven stores and refills,
// a latency-programmable memory model with a scoreboard, and corner sequences.
module tb_mem_request_ctrl;
  import mem_request_ctrl_pkg::*;

  localparam int WIDTH = 32, DEPTH = 1024, ADDR_W = $clog2(DEPTH);
  localparam int WBUF_DEPTH = 4, TIMEOUT_CYC = 8;
  localparam int BW = BLOCK_WORDS * WIDTH;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic wr_accept, rd_done, wbuf_empty, busy;
  logic [BW-1:0] rd_block;

  mem_request_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) mem ();

  mem_request_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WBUF_DEPTH(WBUF_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_accept(wr_accept),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_block(rd_block),
    .wbuf_empty(wbuf_empty), .busy(busy), .mem(mem.master)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [WIDTH-1:0] data; int lat; } wr_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [BW-1:0] blk; int lat; } rd_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [WIDTH-1:0] data; int lat; logic exp_accept; } st_vec_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [ADDR_W-1:0] exp_addr; logic [BW-1:0] blk; int lat; } rf_vec_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];
  st_vec_t st_tab[4];
  rf_vec_t rf_tab[3];

  int checks = 0, failures = 0;
  bit stall = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: pops the scoreboard at the start of each request, checks it,
  // and answers with mem_ready after the entry's latency (unless stalled).
  initial begin : mem_model
    bit active = 1'b0, stalled = 1'b0, is_rd = 1'b0;
    int cnt = 0, hi = 0, lat = 0;
    wr_exp_t cw;
    rd_exp_t cr;
    logic [ADDR_W-1:0] a0;
    logic [WIDTH-1:0]  d0;
    mem.mem_ready = 1'b0;
    mem.mem_read_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem.mem_ready = 1'b0; active = 1'b0; cnt = 0;
        continue;
      end
      if (mem.mem_ready) begin
        mem.mem_ready = 1'b0;
        mem.mem_read_data = ~mem.mem_read_data;
        check("recover_gap", BW'({mem.mem_write_en, mem.mem_read_en}), BW'(2'b00));
        active = 1'b0;
        continue;
      end
      check("en_exclusive", BW'(mem.mem_write_en & mem.mem_read_en), BW'(1'b0));
      if (!active && (mem.mem_write_en || mem.mem_read_en)) begin
        active = 1'b1; cnt = 0; hi = 0; stalled = 1'b0; is_rd = mem.mem_read_en;
        a0 = mem.mem_address; d0 = mem.mem_write_data;
        if (!is_rd) begin
          check("wr_expected", BW'(wq.size() > 0), BW'(1'b1));
          if (wq.size() > 0) begin
            cw = wq.pop_front(); lat = cw.lat;
            check("wr_addr", BW'(mem.mem_address), BW'(cw.addr));
            check("wr_data", BW'(mem.mem_write_data), BW'(cw.data));
          end else lat = 0;
        end else begin
          check("raw_order", BW'(wq.size()), BW'(0));
          check("rd_expected", BW'(rq.size() > 0), BW'(1'b1));
          if (rq.size() > 0) begin
            cr = rq.pop_front(); lat = cr.lat;
            check("rd_addr", BW'(mem.mem_address), BW'(cr.addr));
          end else lat = 0;
        end
      end
      if (active) begin
        if (!(mem.mem_write_en || mem.mem_read_en)) begin
          active = 1'b0;
          continue;
        end
        hi++;
        check("addr_stable", BW'(mem.mem_address), BW'(a0));
        check("data_stable", BW'(mem.mem_write_data), BW'(d0));
        if (stall) stalled = 1'b1;
        else if (cnt == lat) begin
          mem.mem_ready = 1'b1;
          if (is_rd) mem.mem_read_data = cr.blk;
          if (!stalled) check("en_cycles", BW'(hi), BW'(lat + 1));
        end else cnt++;
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(wbuf_empty && !busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", BW'(n < maxc), BW'(1'b1));
  endtask

  task automatic wait_rd_done(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_done && n < maxc);
    check("rd_done_seen", BW'(rd_done), BW'(1'b1));
  endtask

  task automatic push_store(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                            input int lat, input logic exp_acc, input string name);
    @(negedge clk);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    #1;
    check(name, BW'(wr_accept), BW'(exp_acc));
    if (wr_accept) wq.push_back('{a, d, lat});
  endtask

  task automatic do_refill(input rf_vec_t v);
    int n;
    rq.push_back('{v.exp_addr, v.blk, v.lat});
    @(negedge clk);
    rd_req = 1'b1; rd_addr = v.addr;
    wait_rd_done(60, n);
    check("rf_block", rd_block, v.blk);
    check("rf_latency", BW'(n), BW'(v.lat + 2));
    rd_req = 1'b0;
    @(negedge clk);
    check("rf_done_pulse", BW'(rd_done), BW'(1'b0));
    repeat (2) @(negedge clk);
    check("rf_block_hold", rd_block, v.blk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    st_tab[0] = '{10'h010, 32'hDEADBEEF, 2, 1'b1};
    st_tab[1] = '{10'h3FF, 32'h00000000, 0, 1'b1};
    st_tab[2] = '{10'h155, 32'hAAAA5555, 5, 1'b1};
    st_tab[3] = '{10'h2AA, 32'hFFFFFFFF, 1, 1'b1};
    rf_tab[0] = '{10'h107, 10'h104, 128'h44444444_33333333_22222222_11111111, 2};
    rf_tab[1] = '{10'h3FE, 10'h3FC, 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, 0};
    rf_tab[2] = '{10'h001, 10'h000, 128'h80000001_7FFFFFFF_00FF00FF_A5A5A5A5, 4};

    #1 reset = 1'b0;
    #3;
    check("rst_write_en", BW'(mem.mem_write_en), BW'(1'b0));
    check("rst_read_en", BW'(mem.mem_read_en), BW'(1'b0));
    check("rst_address", BW'(mem.mem_address), BW'(0));
    check("rst_wdata", BW'(mem.mem_write_data), BW'(0));
    check("rst_rd_done", BW'(rd_done), BW'(1'b0));
    check("rst_rd_block", rd_block, BW'(0));
    check("rst_busy", BW'(busy), BW'(1'b0));
    check("rst_wbuf_empty", BW'(wbuf_empty), BW'(1'b1));
    check("rst_mem_error", BW'(mem.mem_error), BW'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    // Single stores, each drained before the next.
    for (int i = 0; i < 4; i++) begin
      push_store(st_tab[i].addr, st_tab[i].data, st_tab[i].lat, st_tab[i].exp_accept,
                 $sformatf("st%0d_accept", i));
      @(negedge clk);
      wr_req = 1'b0;
      check("st_queued", BW'(wbuf_empty), BW'(1'b0));
      wait_idle(60);
      check("st_drained", BW'(wbuf_empty), BW'(1'b1));
      check("st_scoreboard", BW'(wq.size()), BW'(0));
    end

    // Fill the buffer against a stalled memory; the fifth store is refused.
    stall = 1'b1;
    for (int i = 0; i < 5; i++)
      push_store(ADDR_W'(10'h200 + i), 32'hF0000000 + i, 0, (i < 4), "fill_accept");
    @(negedge clk);
    wr_req = 1'b0;
    #1 check("fill_still_full", BW'(wr_accept), BW'(1'b0));
    check("fill_not_empty", BW'(wbuf_empty), BW'(1'b0));
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_idle(100);
    check("fill_scoreboard", BW'(wq.size()), BW'(0));

    for (int i = 0; i < 3; i++) do_refill(rf_tab[i]);

    // Two queued stores plus a refill request: stores must reach memory first.
    stall = 1'b1;
    push_store(10'h020, 32'h01234567, 1, 1'b1, "ord_st0");
    push_store(10'h021, 32'h89ABCDEF, 0, 1'b1, "ord_st1");
    rq.push_back('{10'h058, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1});
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'h05A;
    repeat (4) @(negedge clk);
    check("ord_no_read_yet", BW'(mem.mem_read_en), BW'(1'b0));
    stall = 1'b0;
    wait_rd_done(100, n);
    check("ord_block", rd_block, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    check("ord_writes_first", BW'(wq.size()), BW'(0));
    rd_req = 1'b0;
    wait_idle(20);

    // Reset while a refill is waiting on memory with a store buffered.
    stall = 1'b1;
    rq.push_back('{10'h0F0, 128'h1, 0});
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 10'h0F3;
    n = 0;
    while (!mem.mem_read_en && n < 20) begin @(negedge clk); n++; end
    check("rst_rd_started", BW'(mem.mem_read_en), BW'(1'b1));
    wr_req = 1'b1; wr_addr = 10'h0AA; wr_data = 32'h5A5A5A5A;
    #1 check("rst_st_accept", BW'(wr_accept), BW'(1'b1));
    @(negedge clk);
    wr_req = 1'b0;
    check("rst_st_queued", BW'(wbuf_empty), BW'(1'b0));
    #2 reset = 1'b0;
    #1;
    check("midrst_read_en", BW'(mem.mem_read_en), BW'(1'b0));
    check("midrst_write_en", BW'(mem.mem_write_en), BW'(1'b0));
    check("midrst_busy", BW'(busy), BW'(1'b0));
    check("midrst_wbuf_empty", BW'(wbuf_empty), BW'(1'b1));
    check("midrst_rd_block", rd_block, BW'(0));
    rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    push_store(st_tab[0].addr, st_tab[0].data, st_tab[0].lat, 1'b1, "post_rst_accept");
    @(negedge clk);
    wr_req = 1'b0;
    wait_idle(60);
    check("post_rst_scoreboard", BW'(wq.size()), BW'(0));
    do_refill(rf_tab[0]);

`ifdef MEM_REQ_TIMEOUT_EN
    // Memory never answers: the read is abandoned after TIMEOUT_CYC cycles.
    stall = 1'b1;
    rq.push_back('{10'h300, 128'hFFFF, 0});
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 10'h302;
    n = 0;
    while (!mem.mem_read_en && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (mem.mem_read_en && n < 50) begin @(negedge clk); n++; end
    check("tmo_en_cycles", BW'(n), BW'(TIMEOUT_CYC));
    check("tmo_rd_done", BW'(rd_done), BW'(1'b1));
    check("tmo_rd_block", rd_block, BW'(0));
    check("tmo_error", BW'(mem.mem_error), BW'(1'b1));
    rd_req = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    check("tmo_error_sticky", BW'(mem.mem_error), BW'(1'b1));
`else
    check("no_timeout_error", BW'(mem.mem_error), BW'(1'b0));
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_request_ctrl.md
Name: mem_request_ctrl

Overview:
- Initiator side of the main-memory read/write interface; sits between the write-through cache controller and main memory.
- Buffers write-through stores in a small FIFO and drains them one word at a time.
- Issues 4-word block refill reads, captures the returned block and hands it back to the cache.
- Enforces memory handshake sequencing: one request at a time, enables held until ready, one idle cycle between requests.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 1024, memory depth in words; address width ADDR_W = $clog2(DEPTH).
- WBUF_DEPTH, 4, write-buffer entries; must be a power of two ≥ 2.
- TIMEOUT_CYC, 255, ready-wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wr_req  in  1  cache requests a write-through store
- wr_addr  in  ADDR_W  store word address
- wr_data  in  WIDTH  store data
- wr_accept  out  1  store enqueued this cycle (wr_req & !full)
- rd_req  in  1  refill request; level, held by cache until rd_done
- rd_addr  in  ADDR_W  refill address; low 2 bits ignored (block aligned)
- rd_done  out  1  one-cycle pulse, rd_block valid
- rd_block  out  4*WIDTH  refill data; word 0 in [WIDTH-1:0]
- wbuf_empty  out  1  write buffer empty
- busy  out  1  FSM not IDLE
- mem_address  out  ADDR_W  memory address
- mem_write_en  out  1  memory write enable
- mem_read_en  out  1  memory read enable
- mem_write_data  out  WIDTH  memory write data
- mem_ready  in  1  memory completion
- mem_read_data  in  4*WIDTH  memory block data
- mem_error  out  1  sticky timeout flag; tied to 0 without the optional feature

Behaviour:
- Reset (async, active-low) clears FIFO pointers/count, returns FSM to IDLE and zeroes all mem_* outputs, rd_done, rd_block, busy and mem_error. It also sets wbuf_empty=1.
- Reset mid-transaction: enables drop immediately; any in-flight data is discarded.
- Write buffer:
  - Circular FIFO with pointers plus a count of width $clog2(WBUF_DEPTH)+1.
  - wr_accept = wr_req & !full, combinational from registered count. There is no same-cycle bypass: when full, a simultaneous pop does not allow a push.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo WBUF_DEPTH.
- FSM states: IDLE, WRITE, READ, RECOVER.
- IDLE:
  - If FIFO is non-empty, load the head entry into mem_address/mem_write_data, assert mem_write_en and go to WRITE. Writes have priority.
  - Else if rd_req, set mem_address = {rd_addr[ADDR_W-1:2],2'b00}, assert mem_read_en and go to READ.
  - A refill never starts while the buffer holds entries, so memory is always up to date before a refill (no RAW hazard).
- WRITE:
  - Hold address, data and enable stable until mem_ready=1 is sampled.
  - That cycle: pop the FIFO, deassert mem_write_en, go to RECOVER.
- READ:
  - Hold until mem_ready=1 is sampled.
  - That cycle: register rd_block <= mem_read_data, deassert mem_read_en, go to RECOVER.
  - rd_done pulses exactly one cycle, the cycle after capture.
- RECOVER: one cycle with both enables low, then IDLE.
  - Minimum spacing between requests is therefore 1 idle cycle.
  - The cache must drop rd_req in the cycle rd_done is high, otherwise a second refill is issued.
- Invariants: mem_write_en and mem_read_en are never high simultaneously. busy = (state != IDLE).
- Latency: store-to-memory write = queue position + memory latency. Refill = 1 (issue) + memory latency + 1 (rd_done).
- rd_block holds its value until the next refill capture.

Optional Feature:
- Macro MEM_REQ_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to WRITE/READ and increments each cycle without mem_ready.
  - At TIMEOUT_CYC the request is abandoned: enable deasserted, mem_error set (sticky until reset), go to RECOVER.
  - A timed-out write still pops its FIFO entry.
  - A timed-out read pulses rd_done with rd_block set to all zeros.
- When undefined: no counter; the FSM waits indefinitely and mem_error is constant 0.

Decomposition:
- Shared package: FSM state encoding (IDLE/WRITE/READ/RECOVER, 2 bits), BLOCK_WORDS=4, and the block-offset width constant 2.
- One sub-module: mem_wbuf_fifo, the parameterised write buffer with push/pop/full/empty/head outputs.
- FSM and capture logic live in mem_request_ctrl.

Test Plan:
- Single store: wr_req addr=0x010 data=0xDEADBEEF, memory ready after 2 cycles → mem_write_en high 3 cycles with addr 0x010/data stable; FIFO empty after, wbuf_empty=1.
- Fill buffer: 5 back-to-back wr_req while mem_ready held 0 → first 4 accepted, 5th wr_accept=0; release ready → 4 writes issued in order, each separated by 1 idle cycle.
- Refill: rd_req rd_addr=0x107, memory returns 0x4444_3333_2222_1111 (words 3..0) → mem_address=0x104, rd_done 1 cycle, rd_block matches.
- Ordering: 2 stores queued, then rd_req → both writes complete before mem_read_en asserts.
- Reset asserted during READ with mem_ready low → all enables 0 immediately, busy=0, wbuf_empty=1; after release the FSM accepts a fresh request.
- With MEM_REQ_TIMEOUT_EN and TIMEOUT_CYC=8, mem_ready never asserted on a read → enable drops after 8 cycles, mem_error=1, rd_done pulses with rd_block=0.
